tap_decoder: RTL
================

// Module: tap_decoder
// PURPOSE
//  Consumes the single-cycle one_shot pulses from the switch debouncer and groups them into bursts.
//  A burst ends after WINDOW_CYCLES quiet cycles. The block then reports the tap count of the burst:
//  single, double or triple tap, up to MAX_TAPS. The result feeds the user-command logic as a one-cycle strobe.
// PARAMETERS
//  WINDOW_CYCLES  200  quiet cycles after the last pulse that close a burst (>=2)
//  MAX_TAPS       3    saturation value of the tap count (>=1)
//  CNT_W  localparam = $clog2(WINDOW_CYCLES); width of the quiet-window timer
//  TAP_W  localparam = $clog2(MAX_TAPS+1); width of tap_count
// PORTS
//  clk        in   1      system clock, rising edge
//  nrst       in   1      asynchronous active-low reset
//  one_shot   in   1      debounced press pulse, 1 cycle wide, synchronous to clk
//  tap_valid  out  1      1-cycle strobe: burst closed, tap_count valid
//  tap_count  out  TAP_W  taps in the closed burst, 1..MAX_TAPS; held until next strobe
//  busy       out  1      high while a burst is being collected or reported
//  tap_ovf    out  1      burst exceeded MAX_TAPS (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (nrst=0, async): state=IDLE, timer=0, taps=0; all outputs 0.
//  - All outputs are registered. No combinational path from one_shot to any output.
//  - FSM states:
//    IDLE: one_shot=1 -> COLLECT, taps=1, timer=0.
//    COLLECT, one_shot=1: taps=min(taps+1, MAX_TAPS), timer=0, stay.
//    COLLECT, one_shot=0, timer<WINDOW_CYCLES-1: timer+1.
//    COLLECT, one_shot=0, timer==WINDOW_CYCLES-1: -> REPORT; tap_valid=1, tap_count=taps.
//    REPORT (1 cycle): tap_valid returns to 0.
//      one_shot=1 in this cycle -> COLLECT with taps=1, timer=0 (pulse never dropped).
//      otherwise -> IDLE, taps=0.
//  - Latency: last pulse sampled at edge k -> tap_valid high for the cycle after edge k+WINDOW_CYCLES.
//  - Timeout edge and pulse on the same edge: the pulse wins. Count it and restart the window.
//  - The timer never wraps. It is bounded by WINDOW_CYCLES-1 and reset by any pulse.
//  - busy = (state != IDLE), registered alongside the state.
//  - Mid-burst reset: the burst is discarded and no strobe is issued.
//  - one_shot high on consecutive cycles is treated as distinct taps. It is not filtered.
// CONFIGURATION
//  TAP_DECODER_OVF_EN defined:
//    - A sticky burst flag sets when a pulse arrives while taps==MAX_TAPS.
//    - tap_ovf is driven from that flag in the REPORT cycle, together with tap_valid; 0 otherwise.
//    - The flag clears on leaving REPORT.
//  TAP_DECODER_OVF_EN undefined:
//    - The flag logic is not built and tap_ovf is tied 0.
//    - Saturation of tap_count is identical in both builds.
// STRUCTURE
//  - Package tap_pkg:
//    - typedef enum logic [1:0] tap_state_t {IDLE=2'b00, COLLECT=2'b01, REPORT=2'b10}.
//    - Default constants TAP_WINDOW_DEF=200 and TAP_MAX_DEF=3.
//  - Sub-module tap_window_timer (WINDOW_CYCLES):
//    - Inputs clr and run; output expired = (count==WINDOW_CYCLES-1) & run & ~clr.
//    - The FSM, tap counter and output registers stay in tap_decoder.
// TESTING (bench: clk period 10ns; WINDOW_CYCLES=20, MAX_TAPS=3 unless noted)
//  1. nrst low 5ns, then one_shot idle 500ns -> all outputs 0, busy 0; drop nrst mid-run -> outputs 0 asynchronously.
//  2. One pulse at edge k -> busy from k+1; tap_valid=1, tap_count=1 exactly at cycle k+20 only; busy 0 after.
//  3. Pulses at k, k+5, k+12 -> one strobe at k+32 with tap_count=3; no intermediate strobes.
//  4. Five pulses 3 cycles apart -> tap_count=3 (saturated). With TAP_DECODER_OVF_EN, tap_ovf=1 with the strobe; without it, tap_ovf=0.
//  5. Pulse on the timeout edge (k+20 after first) -> no strobe, tap_count=2 at k+40; pulse in the REPORT cycle -> new burst reported as 1.
//  6. Drive the debouncer with the 10ns-bounce / 200ns-stable switch pattern; tap_decoder on its one_shot -> one strobe per stable press, count 1.

Source files
------------

// File: rtl/tap_decoder_pkg.sv
// tap_pkg: shared FSM state encoding and default sizing for the tap decoder.
package tap_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, COLLECT = 2'b01, REPORT = 2'b10} tap_state_t;
  localparam int TAP_WINDOW_DEF = 200;
  localparam int TAP_MAX_DEF = 3;
endpackage

// File: rtl/tap_window_timer.sv
// tap_window_timer: saturating quiet-window timer; expired flags the last quiet cycle of a running window.
module tap_window_timer
  import tap_pkg::*;
#(
  parameter int WINDOW_CYCLES = TAP_WINDOW_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic run,
  output logic expired
);
  localparam int CNT_W = $clog2(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_CYCLES - 1);
  logic [CNT_W-1:0] count_q, count_d;
  assign count_d = clr ? '0 : (run && count_q != LAST) ? count_q + 1'b1 : count_q;
  assign expired = (count_q == LAST) & run & ~clr;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/tap_decoder.sv
// tap_decoder: groups one_shot pulses into bursts closed by a quiet window and strobes the tap count.
// Define TAP_DECODER_OVF_EN to build the burst-overflow flag on tap_ovf; otherwise tap_ovf is tied 0.
module tap_decoder
  import tap_pkg::*;
#(
  parameter int WINDOW_CYCLES = TAP_WINDOW_DEF,
  parameter int MAX_TAPS = TAP_MAX_DEF
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             one_shot,
  output logic                             tap_valid,
  output logic [$clog2(MAX_TAPS+1)-1:0]    tap_count,
  output logic                             busy,
  output logic                             tap_ovf
);
  localparam int TAP_W = $clog2(MAX_TAPS + 1);
  localparam logic [TAP_W-1:0] MAX = TAP_W'(MAX_TAPS);
  tap_state_t state_q;
  logic [TAP_W-1:0] taps_q, count_q;
  logic valid_q, busy_q, expired, at_max;
  assign at_max = taps_q == MAX;
  assign tap_valid = valid_q;
  assign tap_count = count_q;
  assign busy = busy_q;
  // A pulse always clears the window, so a pulse on the timeout edge restarts it instead of closing the burst.
  tap_window_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_timer (
    .clk(clk),
    .nrst(nrst),
    .clr(one_shot | (state_q != COLLECT)),
    .run(state_q == COLLECT),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= IDLE;
      taps_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (one_shot) begin
          state_q <= COLLECT;
          taps_q  <= TAP_W'(1);
          busy_q  <= 1'b1;
        end
        COLLECT: if (one_shot) taps_q <= at_max ? taps_q : taps_q + 1'b1;
        else if (expired) begin
          state_q <= REPORT;
          valid_q <= 1'b1;
          count_q <= taps_q;
        end
        REPORT: begin
          valid_q <= 1'b0;
          state_q <= one_shot ? COLLECT : IDLE;
          taps_q  <= one_shot ? TAP_W'(1) : '0;
          busy_q  <= one_shot;
        end
        default: begin
          state_q <= IDLE;
          taps_q  <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
`ifdef TAP_DECODER_OVF_EN
  logic flag_q, ovf_q;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      flag_q <= (state_q == REPORT) ? 1'b0 : flag_q | ((state_q == COLLECT) & one_shot & at_max);
      ovf_q  <= expired ? flag_q : 1'b0;
    end
  assign tap_ovf = ovf_q;
`else
  assign tap_ovf = 1'b0;
`endif
endmodule
